modn_updown_counter: RTL and testbench

MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

---
 rtl/clock_counter_pkg.sv | 20 ++
 rtl/autorepeat_ctrl.sv | 117 +++++++++++
 rtl/modn_updown_counter.sv | 94 +++++++++
 tb/tb_modn_updown_counter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_counter_pkg.sv
// Shared definitions for the mod-N up/down counter: auto-repeat FSM state
// encoding, step direction constants and a small elaboration helper.
package clock_counter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } ar_state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/autorepeat_ctrl.sv
// Auto-repeat controller: turns level up/down requests into step pulses.
// A press steps at once, then again after HOLD_CYCLES, then every
// REPEAT_CYCLES while the same single input stays high. After reset the
// inputs must be seen released once before any step is allowed.
// Only instantiated when MODN_COUNTER_AUTOREPEAT_EN is defined.
module autorepeat_ctrl
   import clock_counter_pkg::*;
#(
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_up,
   input  logic i_down,
   input  logic i_flush,      // clear or load this cycle
   output logic o_up_step,
   output logic o_down_step
);

   localparam int TW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] RPT_LAST  = TW'(REPEAT_CYCLES - 1);

   ar_state_e       state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   dir_e            dir_q, dir_d;
   logic            armed_q, armed_d;

   logic            single;
   logic            same;
   logic            go;
   logic            fire;
   dir_e            in_dir;

   assign single = i_up ^ i_down;
   assign in_dir = i_down ? DIR_DOWN : DIR_UP;
   assign same   = single & (in_dir == dir_q);
   // any non-single pattern, clear/load, or an unreleased post-reset press parks in IDLE
   assign go     = armed_q & ~i_flush & single;

   // State register: FSM state, repeat timer, stored direction, release-seen flag
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         timer_q <= '0;
         dir_q   <= DIR_UP;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         dir_q   <= dir_d;
         armed_q <= armed_d;
      end
   end

   // Next-state logic: advance the hold/repeat timer while the same key is held
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dir_d   = dir_q;
      armed_d = armed_q | (~i_up & ~i_down);
      if (!go) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = HOLD;
               timer_d = '0;
               dir_d   = in_dir;
            end
            HOLD: begin
               if (!same) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == HOLD_LAST) begin
                  state_d = REPEAT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            REPEAT: begin
               if (!same) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == RPT_LAST) begin
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Output logic: step on a fresh press and on each hold/repeat expiry
   always_comb begin
      fire = 1'b0;
      if (go) begin
         case (state_q)
            IDLE:    fire = 1'b1;
            HOLD:    fire = same & (timer_q == HOLD_LAST);
            REPEAT:  fire = same & (timer_q == RPT_LAST);
            default: fire = 1'b0;
         endcase
      end
      o_up_step   = fire & (in_dir == DIR_UP);
      o_down_step = fire & (in_dir == DIR_DOWN);
   end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with clear, saturating load and combinational
// carry/borrow/step flags suitable for direct cascading into a higher stage.
// Define MODN_COUNTER_AUTOREPEAT_EN to step through the auto-repeat
// controller; otherwise a single-direction request steps every cycle.
module modn_updown_counter
   import clock_counter_pkg::*;
#(
   parameter int MODULUS       = 1000,
   parameter int WIDTH         = 10,
   parameter int HOLD_CYCLES   = 500,
   parameter int REPEAT_CYCLES = 100
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_up,
   input  logic             i_down,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic [WIDTH-1:0] o_count,
   output logic             o_carryup,
   output logic             o_borrowdown,
   output logic             o_step
);

   if (MODULUS < 2 || WIDTH < 1 || (2 ** WIDTH) < MODULUS) begin : g_bad_width
      $error("modn_updown_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
   end
   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_timing
      $error("modn_updown_counter: need HOLD_CYCLES >= 2 and REPEAT_CYCLES >= 1");
   end

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic             both_hi;
   logic             blocked;
   logic             up_req, dn_req;
   logic             up_eff, dn_eff;
   logic [WIDTH-1:0] load_sat;
   logic [WIDTH-1:0] count_d;

`ifdef MODN_COUNTER_AUTOREPEAT_EN
   autorepeat_ctrl #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_autorepeat (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_up        (i_up),
      .i_down      (i_down),
      .i_flush     (i_clear | i_load),
      .o_up_step   (up_req),
      .o_down_step (dn_req)
   );
`else
   assign up_req = i_up & ~i_down;
   assign dn_req = i_down & ~i_up;
`endif

   assign both_hi  = i_up & i_down;
   assign blocked  = i_clear | i_load | both_hi;
   // reset gating keeps the flags quiet even if a request is held during reset
   assign up_eff   = i_rstn & ~blocked & up_req;
   assign dn_eff   = i_rstn & ~blocked & dn_req;

   assign o_step       = up_eff | dn_eff;
   assign o_carryup    = up_eff & (o_count == MAX_CNT);
   assign o_borrowdown = dn_eff & (o_count == '0);

   assign load_sat = (i_load_value > MAX_CNT) ? MAX_CNT : i_load_value;

   // Next count: clear > load > both-high clear > step > hold
   always_comb begin
      count_d = o_count;
      if (i_clear) begin
         count_d = '0;
      end else if (i_load) begin
         count_d = load_sat;
      end else if (both_hi) begin
         count_d = '0;
      end else if (up_eff) begin
         count_d = (o_count == MAX_CNT) ? '0 : o_count + WIDTH'(1);
      end else if (dn_eff) begin
         count_d = (o_count == '0) ? MAX_CNT : o_count - WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) o_count <= '0;
      else         o_count <= count_d;
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter (MODULUS=60, WIDTH=6, HOLD=4, REPEAT=2).
// Inputs change 1 time unit after a rising edge; flags are sampled 1 unit
// later, the count 1 unit after the following edge.
module tb_modn_updown_counter;

   logic       clk;
   logic       rstn;
   logic       up, down, clr, ld;
   logic [5:0] ldv;
   logic [5:0] count;
   logic       carry, borrow, step;

   int tests_run;
   int tests_failed;

   modn_updown_counter #(
      .MODULUS       (60),
      .WIDTH         (6),
      .HOLD_CYCLES   (4),
      .REPEAT_CYCLES (2)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_up         (up),
      .i_down       (down),
      .i_clear      (clr),
      .i_load       (ld),
      .i_load_value (ldv),
      .o_count      (count),
      .o_carryup    (carry),
      .o_borrowdown (borrow),
      .o_step       (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_val(input logic [5:0] v);
      ld = 1'b1; ldv = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0; up = 1'b1; down = 1'b0; clr = 1'b0; ld = 1'b0; ldv = '0;
      #3;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
      tests_run++;
      if (step !== 1'b0 || carry !== 1'b0 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags: step=%b carry=%b borrow=%b want 000", step, carry, borrow);
      end
      up = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      tick(); tick();
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL reset_release: got %0d want 0", count); end
   endtask

   task automatic test_load;
      ld = 1'b1; ldv = 6'd45; up = 1'b1;
      #1;
      tests_run++;
      if (step !== 1'b0) begin tests_failed++; $display("FAIL load_step: got %b want 0", step); end
      tick();
      up = 1'b0;
      tests_run++;
      if (count !== 6'd45) begin tests_failed++; $display("FAIL load45: got %0d want 45", count); end
      ldv = 6'd63;
      tick();
      tests_run++;
      if (count !== 6'd59) begin tests_failed++; $display("FAIL load63_sat: got %0d want 59", count); end
      clr = 1'b1; ldv = 6'd30;
      tick();
      clr = 1'b0; ld = 1'b0;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL clear_over_load: got %0d want 0", count); end
      tick();
   endtask

   task automatic test_wrap;
      load_val(6'd59);
      up = 1'b1;
      #1;
      tests_run++;
      if (carry !== 1'b1 || step !== 1'b1) begin
         tests_failed++; $display("FAIL carry_at_59: carry=%b step=%b want 1 1", carry, step);
      end
      tick();
      up = 1'b0;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL wrap_up: got %0d want 0", count); end
      tick();
      down = 1'b1;
      #1;
      tests_run++;
      if (borrow !== 1'b1 || step !== 1'b1) begin
         tests_failed++; $display("FAIL borrow_at_0: borrow=%b step=%b want 1 1", borrow, step);
      end
      tick();
      down = 1'b0;
      tests_run++;
      if (count !== 6'd59) begin tests_failed++; $display("FAIL wrap_down: got %0d want 59", count); end
      tick();
      load_val(6'd10);
      up = 1'b1;
      #1;
      tests_run++;
      if (carry !== 1'b0 || step !== 1'b1) begin
         tests_failed++; $display("FAIL up_mid: carry=%b step=%b want 0 1", carry, step);
      end
      tick();
      up = 1'b0;
      tests_run++;
      if (count !== 6'd11) begin tests_failed++; $display("FAIL up_mid_count: got %0d want 11", count); end
      tick();
      down = 1'b1;
      #1;
      tests_run++;
      if (borrow !== 1'b0 || step !== 1'b1) begin
         tests_failed++; $display("FAIL down_mid: borrow=%b step=%b want 0 1", borrow, step);
      end
      tick();
      down = 1'b0;
      tests_run++;
      if (count !== 6'd10) begin tests_failed++; $display("FAIL down_mid_count: got %0d want 10", count); end
      tick();
   endtask

   task automatic test_both_high;
      load_val(6'd22);
      up = 1'b1; down = 1'b1;
      #1;
      tests_run++;
      if (step !== 1'b0 || carry !== 1'b0 || borrow !== 1'b0) begin
         tests_failed++; $display("FAIL both22_flags: step=%b carry=%b borrow=%b want 000", step, carry, borrow);
      end
      tick();
      up = 1'b0; down = 1'b0;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL both22_count: got %0d want 0", count); end
      tick();
      load_val(6'd59);
      up = 1'b1; down = 1'b1;
      #1;
      tests_run++;
      if (carry !== 1'b0 || step !== 1'b0) begin
         tests_failed++; $display("FAIL both59_flags: carry=%b step=%b want 0 0", carry, step);
      end
      tick();
      up = 1'b0; down = 1'b0;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL both59_count: got %0d want 0", count); end
      tick();
   endtask

   task automatic test_clear;
      load_val(6'd30);
      clr = 1'b1; up = 1'b1;
      #1;
      tests_run++;
      if (step !== 1'b0) begin tests_failed++; $display("FAIL clear_step: got %b want 0", step); end
      tick();
      clr = 1'b0; up = 1'b0;
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL clear_count: got %0d want 0", count); end
      tick();
   endtask

`ifdef MODN_COUNTER_AUTOREPEAT_EN
   task automatic test_autorepeat;
      logic exp_step;
      load_val(6'd10);
      up = 1'b1;
      for (int c = 0; c < 12; c++) begin
         exp_step = (c == 0 || c == 4 || c == 6 || c == 8 || c == 10);
         #1;
         tests_run++;
         if (step !== exp_step) begin
            tests_failed++; $display("FAIL repeat_step c%0d: got %b want %b", c, step, exp_step);
         end
         tick();
      end
      up = 1'b0;
      tests_run++;
      if (count !== 6'd15) begin tests_failed++; $display("FAIL repeat_count: got %0d want 15", count); end
      tick();
   endtask

   task automatic test_reversal;
      logic exp_step;
      load_val(6'd20);
      for (int c = 0; c < 5; c++) begin
         up   = (c < 3);
         down = (c >= 3);
         exp_step = (c == 0 || c == 4);
         #1;
         tests_run++;
         if (step !== exp_step) begin
            tests_failed++; $display("FAIL reversal_step c%0d: got %b want %b", c, step, exp_step);
         end
         tick();
      end
      up = 1'b0; down = 1'b0;
      tests_run++;
      if (count !== 6'd20) begin tests_failed++; $display("FAIL reversal_count: got %0d want 20", count); end
      tick();
   endtask

   task automatic test_reset_mid;
      load_val(6'd33);
      up = 1'b1;
      for (int c = 0; c < 9; c++) tick();
      tests_run++;
      if (count !== 6'd37) begin tests_failed++; $display("FAIL pre_reset_count: got %0d want 37", count); end
      #2;
      rstn = 1'b0;
      #1;
      tests_run++;
      if (count !== 6'd0 || step !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mid: count=%0d step=%b want 0 0", count, step);
      end
      tick();
      rstn = 1'b1;
      #1;
      tests_run++;
      if (step !== 1'b0) begin tests_failed++; $display("FAIL held_after_release: step=%b want 0", step); end
      tick();
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL held_count: got %0d want 0", count); end
      up = 1'b0;
      tick();
      up = 1'b1;
      #1;
      tests_run++;
      if (step !== 1'b1) begin tests_failed++; $display("FAIL fresh_press: step=%b want 1", step); end
      tick();
      up = 1'b0;
      tests_run++;
      if (count !== 6'd1) begin tests_failed++; $display("FAIL fresh_count: got %0d want 1", count); end
      tick();
   endtask
`else
   task automatic test_continuous;
      logic [5:0] exp_cnt [3];
      exp_cnt[0] = 6'd59; exp_cnt[1] = 6'd0; exp_cnt[2] = 6'd1;
      load_val(6'd58);
      up = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (step !== 1'b1 || carry !== (c == 1)) begin
            tests_failed++; $display("FAIL cont_up c%0d: step=%b carry=%b", c, step, carry);
         end
         tick();
         tests_run++;
         if (count !== exp_cnt[c]) begin
            tests_failed++; $display("FAIL cont_up_count c%0d: got %0d want %0d", c, count, exp_cnt[c]);
         end
      end
      up = 1'b0; down = 1'b1;
      tick();
      tick();
      down = 1'b0;
      tests_run++;
      if (count !== 6'd59) begin tests_failed++; $display("FAIL cont_down: got %0d want 59", count); end
      tick();
   endtask

   task automatic test_reset_mid;
      load_val(6'd37);
      up = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      tests_run++;
      if (count !== 6'd0 || step !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mid: count=%0d step=%b want 0 0", count, step);
      end
      up = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      tests_run++;
      if (count !== 6'd0) begin tests_failed++; $display("FAIL reset_mid_release: got %0d want 0", count); end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_load();
      test_wrap();
      test_both_high();
      test_clear();
`ifdef MODN_COUNTER_AUTOREPEAT_EN
      test_autorepeat();
      test_reversal();
`else
      test_continuous();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
